// File: rtl/fifo_sync_thr.sv
// rtl/fifo_sync_thr.sv - single-clock FIFO with thresholds, sticky errors, flush; FIFO_FWFT_EN selects fall-through reads
module fifo_sync_thr #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_THR  = 12,
    parameter int AEMPTY_THR = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fifo_counter,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THR);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THR);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic                  do_push;
    logic                  do_pop;
    logic                  ovf_set;
    logic                  udf_set;

    // Flags decode straight from the registered count so they never lag it.
    assign empty        = (fifo_counter == '0);
    assign full         = (fifo_counter == DEPTH_C);
    assign almost_empty = (fifo_counter <= AEMPTY_C);
    assign almost_full  = (fifo_counter >= AFULL_C);

    // A pop on a full FIFO frees the slot the push needs, so both proceed.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (!flush) begin
            do_push = push & (~full | pop);
            do_pop  = pop & ~empty;
            ovf_set = push & full & ~pop;
            udf_set = pop & empty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            fifo_counter <= '0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            fifo_counter <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fifo_counter <= fifo_counter + 1'b1;
                2'b01:   fifo_counter <= fifo_counter - 1'b1;
                default: fifo_counter <= fifo_counter;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= data_in;
        end
    end

    // A new error in the same cycle as clr_err takes precedence over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    always_comb begin
        data_out = '0;
        if (!empty) begin
            data_out = mem[head];
        end
    end
`else
    // Nonblocking read of mem[head] returns the old word even when a full
    // FIFO overwrites that slot in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (flush) begin
            data_out <= '0;
        end else if (do_pop) begin
            data_out <= mem[head];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_thr.sv
// tb/tb_fifo_sync_thr.sv - table-driven self-checking bench for fifo_sync_thr
module tb_fifo_sync_thr;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       flush;
    logic       clr_err;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [4:0] fifo_counter;
    logic       overflow;
    logic       underflow;

    int tests_run;
    int tests_failed;

    typedef struct {
        string      name;
        logic       push;
        logic       pop;
        logic       flush;
        logic       clr;
        logic [7:0] din;
        int         cnt;
        logic [7:0] dout;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vecs[$];

    fifo_sync_thr #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .AFULL_THR(12),
        .AEMPTY_THR(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(flush),
        .clr_err(clr_err),
        .data_in(data_in),
        .data_out(data_out),
        .empty(empty),
        .full(full),
        .almost_empty(almost_empty),
        .almost_full(almost_full),
        .fifo_counter(fifo_counter),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic check_state(input string n, input int cnt, input logic [7:0] dout,
                               input logic dchk, input logic ov, input logic un);
        chk({n, ".count"}, int'(fifo_counter), cnt);
        chk({n, ".empty"}, int'(empty), int'(cnt == 0));
        chk({n, ".full"}, int'(full), int'(cnt == 16));
        chk({n, ".aempty"}, int'(almost_empty), int'(cnt <= 4));
        chk({n, ".afull"}, int'(almost_full), int'(cnt >= 12));
        chk({n, ".overflow"}, int'(overflow), int'(ov));
        chk({n, ".underflow"}, int'(underflow), int'(un));
        if (dchk) begin
            chk({n, ".data_out"}, int'(data_out), int'(dout));
        end
    endtask

    task automatic add(input string n, input logic pu, input logic po, input logic fl,
                       input logic cl, input logic [7:0] din, input int cnt,
                       input logic [7:0] dout, input logic ov, input logic un);
        vec_t v;
        v.name = n; v.push = pu; v.pop = po; v.flush = fl; v.clr = cl;
        v.din = din; v.cnt = cnt; v.dout = dout; v.ov = ov; v.un = un;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic pu, input logic po, input logic fl,
                         input logic cl, input logic [7:0] din);
        push = pu; pop = po; flush = fl; clr_err = cl; data_in = din;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic dchk;

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = '0;
`ifdef FIFO_FWFT_EN
        dchk = 1'b0;
`else
        dchk = 1'b1;
`endif

        for (int i = 1; i <= 16; i++) add("t1_push", 1, 0, 0, 0, 8'(i), i, 8'h00, 0, 0);
        add("t3_ovf", 1, 0, 0, 0, 8'hAA, 16, 8'h00, 1, 0);
        add("t3_clr", 0, 0, 0, 1, 8'h00, 16, 8'h00, 0, 0);
        for (int i = 1; i <= 16; i++) add("t2_pop", 0, 1, 0, 0, 8'h00, 16 - i, 8'(i), 0, 0);
        add("t4_udf", 0, 1, 0, 0, 8'h00, 0, 8'h10, 0, 1);
        add("t4_pp_empty", 1, 1, 0, 0, 8'h55, 1, 8'h10, 0, 1);
        add("t4_clr_pop", 0, 1, 0, 1, 8'h00, 0, 8'h55, 0, 0);
        add("t4_set_wins", 0, 1, 0, 1, 8'h00, 0, 8'h55, 0, 1);
        add("t4_clr", 0, 0, 0, 1, 8'h00, 0, 8'h55, 0, 0);
        for (int i = 0; i < 10; i++) add("t5_push10", 1, 0, 0, 0, 8'(8'h30 + i), i + 1, 8'h55, 0, 0);
        for (int i = 0; i < 10; i++) add("t5_pop10", 0, 1, 0, 0, 8'h00, 9 - i, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < 12; i++) add("t5_push12", 1, 0, 0, 0, 8'(8'h20 + i), i + 1, 8'h39, 0, 0);
        for (int i = 0; i < 7; i++) add("t5_pop7", 0, 1, 0, 0, 8'h00, 11 - i, 8'(8'h20 + i), 0, 0);
        add("t5_pp_mid", 1, 1, 0, 0, 8'h2C, 5, 8'h27, 0, 0);
        for (int i = 0; i < 5; i++) add("t5_pop5", 0, 1, 0, 0, 8'h00, 4 - i, 8'(8'h28 + i), 0, 0);
        for (int i = 0; i < 16; i++) add("fill", 1, 0, 0, 0, 8'(8'h40 + i), i + 1, 8'h2C, 0, 0);
        add("pp_full", 1, 1, 0, 0, 8'h50, 16, 8'h40, 0, 0);
        add("pop_after_pp", 0, 1, 0, 0, 8'h00, 15, 8'h41, 0, 0);
        add("flush_busy", 1, 1, 1, 0, 8'h77, 0, 8'h00, 0, 0);
        add("flush_pop_empty", 0, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        for (int i = 0; i < 7; i++) add("t6_push7", 1, 0, 0, 0, 8'(8'h60 + i), i + 1, 8'h00, 0, 0);
        add("t6_flush", 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0);

        #21;
        check_state("reset", 0, 8'h00, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_state("idle", 0, 8'h00, 1'b1, 1'b0, 1'b0);

        foreach (vecs[k]) begin
            drive(vecs[k].push, vecs[k].pop, vecs[k].flush, vecs[k].clr, vecs[k].din);
            check_state(vecs[k].name, vecs[k].cnt, vecs[k].dout, dchk, vecs[k].ov, vecs[k].un);
        end

        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_state("pre_rst_udf", 0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h70 + i));
        push = 1'b1; data_in = 8'h7F;
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst", 0, 8'h00, 1'b1, 1'b0, 1'b0);
        push = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_state("after_rst", 0, 8'h00, 1'b1, 1'b0, 1'b0);

`ifdef FIFO_FWFT_EN
        do_reset();
        check_state("fwft_empty", 0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
            check_state("fwft_push", i, 8'h01, 1'b1, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_state("fwft_hold", 16, 8'h01, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            check_state("fwft_pop", 16 - i, (i < 16) ? 8'(i + 1) : 8'h00, 1'b1, 1'b0, 1'b0);
        end
`else
        do_reset();
        check_state("std_reset2", 0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
